// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_ctrl
//  Description : Single-port synchronous data memory controller for the MEM
//                stage. Accepts one load/store per valid/ready handshake,
//                inserts WAIT_STATES programmable wait cycles, merges
//                byte/half stores into the addressed big-endian lanes and
//                returns sign/zero-extended sub-word loads. Size, alignment
//                and range faults are reported through resp_err.
//
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-high reset
//                req_valid  - request present
//                req_ready  - block can accept a request (IDLE, not in reset)
//                req_we     - 1 = store, 0 = load
//                req_size   - 00 byte, 01 half, 10 word, 11 illegal
//                req_signed - sign-extend sub-word loads
//                req_addr   - byte address
//                req_wdata  - right-justified store data
//                resp_valid - one-cycle response strobe
//                resp_rdata - load result (0 for stores and faults)
//                resp_err   - access fault, qualified by resp_valid
//
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int    ADDR_W      = 32,
    parameter int    DEPTH       = 2048,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int                c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        c_WAIT  = 4'(WAIT_STATES);
    localparam logic [ADDR_W-3:0] c_DEPTH = (ADDR_W-2)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;

    // Captured request
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_rd_word;

    logic              w_accept;
    logic              w_err;
    logic              w_do_write;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [1:0]        w_lane;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (c_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_WAIT;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request fields are only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fault decode on the captured request. All faults raise the same
    // flag; the order only documents which one is considered first.
    // ------------------------------------------------------------------
    always_comb begin
        w_err = 1'b0;
        if (r_size == 2'b11) begin
            w_err = 1'b1;
        end else if ((r_size == 2'b01 && r_addr[0]) ||
                     (r_size == 2'b10 && r_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end else if (r_addr[ADDR_W-1:2] >= c_DEPTH) begin
            w_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Array access. The read port follows the live request address while
    // IDLE so that a zero-wait-state access has its word ready in RESP;
    // otherwise it tracks the captured address. Stores are a
    // read-modify-write: the word read on entry to RESP is merged and
    // written back on the edge that raises resp_valid.
    // ------------------------------------------------------------------
    assign w_rd_idx   = (r_state == ST_IDLE) ? req_addr[c_IDX_W+1:2]
                                             : r_addr[c_IDX_W+1:2];
    assign w_wr_idx   = r_addr[c_IDX_W+1:2];
    assign w_do_write = (r_state == ST_RESP) && !rst && r_we && !w_err;

    always_ff @(posedge clk) begin
        r_rd_word <= r_mem[w_rd_idx];
        if (w_do_write) begin
            r_mem[w_wr_idx] <= w_merged;
        end
    end

    // Big-endian: byte offset 0 lives in bits [31:24].
    assign w_lane = 2'd3 - r_addr[1:0];
    assign w_byte = r_rd_word[{w_lane, 3'b000} +: 8];
    assign w_half = r_rd_word[{~r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_merged = r_rd_word;
        case (r_size)
            2'b00:   w_merged[{w_lane, 3'b000} +: 8]       = r_wdata[7:0];
            2'b01:   w_merged[{~r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged                              = r_wdata;
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = r_rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Response. Data and error hold between strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (r_state == ST_RESP) begin
            resp_valid <= 1'b1;
            resp_err   <= w_err;
            resp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
        end else begin
            resp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
